// File: rtl/fdc_pkg.sv
// Shared constants and types for the FDC accumulate-and-dump decimator.
package fdc_pkg;

    localparam int FDC_IN_W     = 4;
    localparam int FDC_ACC_W    = 16;
    localparam int FDC_LOG2_MAX = 7;
    localparam int FDC_DEC_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic [FDC_ACC_W-1:0] out_word_t;

endpackage

// File: rtl/fdc_decimator_if.sv
// Bus bundle between the FDC core, the decimator and the output mux.
// valid/ready: a word moves only on a cycle where out_valid && out_ready at the clock edge; the producer holds out_data stable until then unless a newer dump replaces it.
interface fdc_decimator_if
    import fdc_pkg::*;
#(
    parameter int IN_W  = FDC_IN_W,
    parameter int ACC_W = FDC_ACC_W
);
    logic                 en;
    logic                 restart;
    logic [FDC_DEC_W-1:0] dec_log2;
    logic                 in_valid;
    logic [IN_W-1:0]      in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;
    logic                 overrun;
    logic                 busy;
    state_t               state_dbg;

    modport master (
        output en, restart, dec_log2, in_valid, in_data, out_ready,
        input  out_valid, out_data, overrun, busy, state_dbg
    );

    modport slave (
        input  en, restart, dec_log2, in_valid, in_data, out_ready,
        output out_valid, out_data, overrun, busy, state_dbg
    );

endinterface

// File: rtl/fdc_out_reg.sv
// Single-entry valid/ready holding register; a new load replaces an unaccepted word and raises the sticky overrun flag.
module fdc_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         ready,
    input  logic         clr_ovr,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         overrun
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= data_in;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            // Overwrite is only lost data when the old word is not leaving this cycle.
            if (clr_ovr) begin
                overrun <= 1'b0;
            end else if (load && valid && !ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fdc_decimator.sv
// Accumulate-and-dump decimator: sums 2^N FDC samples into one output word.
// Optional macro FDC_DEC_NORM_EN outputs the rounded window mean instead of the raw sum.
module fdc_decimator
    import fdc_pkg::*;
#(
    parameter int IN_W     = FDC_IN_W,
    parameter int ACC_W    = FDC_ACC_W,
    parameter int LOG2_MAX = FDC_LOG2_MAX
) (
    input logic           clk,
    input logic           rst,
    fdc_decimator_if.slave bus
);

    localparam int CNT_W = LOG2_MAX + 1;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FDC_DEC_W-1:0] ratio_q, ratio_d;
    logic [FDC_DEC_W-1:0] ratio_in;
    logic [ACC_W-1:0]     sample;
    logic [ACC_W-1:0]     sum;
    logic [CNT_W-1:0]     last_cnt;
    logic                 accept;
    logic                 dump;
    logic [ACC_W-1:0]     dump_sum;
    out_word_t            dump_word;
    logic                 out_valid;
    logic [ACC_W-1:0]     out_data;
    logic                 overrun;

    assign accept   = bus.en && bus.in_valid;
    assign ratio_in = (int'(bus.dec_log2) > LOG2_MAX) ? FDC_DEC_W'(LOG2_MAX) : bus.dec_log2;
    assign sample   = ACC_W'(bus.in_data);
    assign sum      = acc_q + sample;
    assign last_cnt = CNT_W'((32'd1 << ratio_q) - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ratio_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
        end
    end

    // restart takes priority and swallows any sample arriving with it.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        dump     = 1'b0;
        dump_sum = '0;
        if (bus.restart) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    ratio_d = ratio_in;
                    if (ratio_in == '0) begin
                        dump     = 1'b1;
                        dump_sum = sample;
                    end else begin
                        acc_d   = sample;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (cnt_q == last_cnt) begin
                        dump     = 1'b1;
                        dump_sum = sum;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef FDC_DEC_NORM_EN
    logic [FDC_DEC_W-1:0] dump_log2;
    logic [ACC_W-1:0]     round_add;

    // Window exponent is the freshly latched one for pass-through, the held one otherwise.
    always_comb begin
        dump_log2 = (state_q == IDLE) ? ratio_in : ratio_q;
        round_add = '0;
        if (dump_log2 != '0) begin
            round_add = ACC_W'(1) << (dump_log2 - FDC_DEC_W'(1));
        end
        dump_word = (dump_sum + round_add) >> dump_log2;
    end
`else
    assign dump_word = dump_sum;
`endif

    fdc_out_reg #(
        .W(ACC_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (dump),
        .data_in (dump_word),
        .ready   (bus.out_ready),
        .clr_ovr (bus.restart),
        .valid   (out_valid),
        .data    (out_data),
        .overrun (overrun)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.overrun   = overrun;
    assign bus.busy      = (state_q == ACCUM);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fdc_decimator.sv
// Self-checking bench for fdc_decimator: directed windows, restart/reset, en freeze and random traffic.
module tb_fdc_decimator;
    import fdc_pkg::*;

    logic clk;
    logic rst;

    fdc_decimator_if bus ();

    fdc_decimator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;

    logic [31:0] exp_q[$];

    int m_acc;
    int m_cnt;
    int m_ratio;
    bit m_busy;
    bit m_valid;
    bit m_ovr;
    int m_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int norm(input int v, input int r);
        int res;
        res = v;
`ifdef FDC_DEC_NORM_EN
        if (r != 0) res = (v + (1 << (r - 1))) >> r;
`else
        if (r < 0) res = 0;
`endif
        return res;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_ratio = 0;
        m_busy = 0; m_valid = 0; m_ovr = 0; m_data = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check_eq({tag, "_overrun"},   32'(bus.overrun),   32'(m_ovr));
        check_eq({tag, "_busy"},      32'(bus.busy),      32'(m_busy));
        check_eq({tag, "_out_data"},  32'(bus.out_data),  32'(m_data));
    endtask

    // One clock: predict from the currently driven inputs, advance, compare.
    task automatic tick();
        bit dump;
        int val;
        int r;
        dump = 0; val = 0; r = m_ratio;
        if (bus.restart) begin
            m_acc = 0; m_cnt = 0; m_busy = 0; m_ovr = 0;
        end else if (bus.en && bus.in_valid) begin
            if (!m_busy) begin
                r = (int'(bus.dec_log2) > FDC_LOG2_MAX) ? FDC_LOG2_MAX : int'(bus.dec_log2);
                m_ratio = r;
                if (r == 0) begin
                    dump = 1; val = int'(bus.in_data);
                end else begin
                    m_acc = int'(bus.in_data); m_cnt = 1; m_busy = 1;
                end
            end else if (m_cnt == (1 << m_ratio) - 1) begin
                dump = 1; val = m_acc + int'(bus.in_data);
                m_acc = 0; m_cnt = 0; m_busy = 0;
            end else begin
                m_acc += int'(bus.in_data); m_cnt++;
            end
        end
        if (dump) begin
            if (m_valid && !bus.out_ready) m_ovr = 1;
            m_valid = 1;
            exp_q.push_back(32'(norm(val, r)));
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        if (dump) m_data = int'(exp_q.pop_front());
        check_outputs("tick");
    endtask

    task automatic send(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'(d);
        tick();
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        check_outputs("rst");
    endtask

    initial begin
        compared = 0; mismatched = 0;
        bus.en = 1'b1; bus.restart = 1'b0; bus.dec_log2 = 3'd0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset");
        check_eq("reset_state", 32'(bus.state_dbg), 32'(IDLE));

        // Basic 4-sample window
        bus.dec_log2 = 3'd2;
        send(1); send(2); send(3); send(4);
`ifdef FDC_DEC_NORM_EN
        check_eq("t1_word", 32'(bus.out_data), 32'd3);
`else
        check_eq("t1_word", 32'(bus.out_data), 32'd10);
`endif
        tick();

        // Pass-through
        bus.dec_log2 = 3'd0;
        send(7);
        check_eq("t2_first", 32'(bus.out_data), 32'd7);
        send(9);
        check_eq("t2_second", 32'(bus.out_data), 32'd9);
        tick();

        // Backpressure overrun, then drain
        bus.dec_log2 = 3'd1;
        bus.out_ready = 1'b0;
        send(5); send(5); send(6); send(6);
        check_eq("t3_overrun", 32'(bus.overrun), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        tick();
        check_eq("t3_drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Dump coinciding with transfer
        pulse_restart();
        send(5); send(5); send(6);
        bus.out_ready = 1'b1;
        send(6);
        check_eq("t4_no_overrun", 32'(bus.overrun), 32'd0);
        tick();

        // restart mid-window, then rst mid-window
        bus.dec_log2 = 3'd2;
        send(3); send(3);
        bus.in_valid = 1'b1; bus.in_data = 4'd9;
        pulse_restart();
        send(1); send(1); send(1); send(1);
        send(3); send(3);
        pulse_rst();
        send(1); send(1); send(1); send(1);
        tick();

        // Exponent change mid-window is ignored
        bus.dec_log2 = 3'd2;
        send(2);
        bus.dec_log2 = 3'd0;
        send(2); send(2); send(2);
        send(2);
        tick();

        // en low freezes the window
        bus.dec_log2 = 3'd1;
        send(3);
        bus.en = 1'b0;
        send(15); send(15);
        bus.en = 1'b1;
        send(4);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.en        = ($urandom_range(0, 7) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.restart   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 15) == 0) bus.dec_log2 = 3'($urandom_range(0, 3));
            tick();
        end

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
